// File: rtl/gmii_frame_mux_if.sv
// GMII source/sink bundle for the frame-safe transmit multiplexer.
// Slave side is the mux; master side is whoever drives the sources.
interface gmii_frame_mux_if #(
    parameter int C_NUM_INPUTS = 8,
    parameter int C_SEL_WIDTH  = 8
) ();
    logic [8*C_NUM_INPUTS-1:0] gmii_in_txd;
    logic [C_NUM_INPUTS-1:0]   gmii_in_tx_en;
    logic [C_NUM_INPUTS-1:0]   gmii_in_tx_er;
    logic [C_SEL_WIDTH-1:0]    select;
    logic [7:0]                gmii_out_txd;
    logic                      gmii_out_tx_en;
    logic                      gmii_out_tx_er;
    logic [C_SEL_WIDTH-1:0]    active_sel;
    logic                      switch_pending;
    logic [31:0]               frame_count;
    logic [15:0]               drop_count;

    modport master (
        output gmii_in_txd, gmii_in_tx_en, gmii_in_tx_er, select,
        input  gmii_out_txd, gmii_out_tx_en, gmii_out_tx_er,
        input  active_sel, switch_pending, frame_count, drop_count
    );

    modport slave (
        input  gmii_in_txd, gmii_in_tx_en, gmii_in_tx_er, select,
        output gmii_out_txd, gmii_out_tx_en, gmii_out_tx_er,
        output active_sel, switch_pending, frame_count, drop_count
    );
endinterface

// File: rtl/gmii_frame_mux.sv
// N-input GMII transmit mux that only switches sources between frames,
// inserts an inter-frame gap after each switch and drops partial frames.
module gmii_frame_mux #(
    parameter int C_NUM_INPUTS = 8,
    parameter int C_SEL_WIDTH  = 8,
    parameter int C_MIN_IFG    = 12
) (
    input  logic gtx_clk,
    input  logic gtx_resetn,
    gmii_frame_mux_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FRAME = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DISC  = 2'd3;

    localparam logic [7:0] GAP_INIT = 8'(C_MIN_IFG - 1);

    logic [C_SEL_WIDTH-1:0]    sel1;
    logic [C_NUM_INPUTS-1:0]   en1;
    logic [C_NUM_INPUTS-1:0]   er1;
    logic [8*C_NUM_INPUTS-1:0] txd1;

    logic [1:0]             state;
    logic [7:0]             gap_cnt;
    logic                   warm;
    logic [C_SEL_WIDTH-1:0] active_sel;
    logic                   pending;
    logic [31:0]            frame_cnt;
    logic [15:0]            drop_cnt;
    logic [7:0]             out_txd;
    logic                   out_en;
    logic                   out_er;

    logic                   src_en;
    logic                   src_er;
    logic [7:0]             src_txd;
    logic                   do_switch;
    logic [C_SEL_WIDTH-1:0] act_nxt;

    // An out-of-range active_sel matches no source and reads as idle.
    always_comb begin
        src_en  = 1'b0;
        src_er  = 1'b0;
        src_txd = 8'h00;
        for (int i = 0; i < C_NUM_INPUTS; i++) begin
            if (active_sel == C_SEL_WIDTH'(i)) begin
                src_en  = en1[i];
                src_er  = er1[i];
                src_txd = txd1[8*i +: 8];
            end
        end
    end

    always_comb begin
        do_switch = (state == S_IDLE) && (sel1 != active_sel);
        act_nxt   = do_switch ? sel1 : active_sel;
    end

    always_ff @(posedge gtx_clk or negedge gtx_resetn) begin
        if (!gtx_resetn) begin
            sel1       <= '0;
            en1        <= '0;
            er1        <= '0;
            txd1       <= '0;
            state      <= S_DISC;
            gap_cnt    <= 8'h00;
            warm       <= 1'b0;
            active_sel <= '0;
            pending    <= 1'b0;
            frame_cnt  <= 32'h0;
            drop_cnt   <= 16'h0;
            out_txd    <= 8'h00;
            out_en     <= 1'b0;
            out_er     <= 1'b0;
        end else begin
            sel1    <= bus.select;
            en1     <= bus.gmii_in_tx_en;
            er1     <= bus.gmii_in_tx_er;
            txd1    <= bus.gmii_in_txd;
            warm    <= 1'b1;
            pending <= (sel1 != act_nxt);
            out_txd <= 8'h00;
            out_en  <= 1'b0;
            out_er  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (do_switch) begin
                        active_sel <= sel1;
                        gap_cnt    <= GAP_INIT;
                        state      <= S_GAP;
                    end else if (src_en) begin
                        state   <= S_FRAME;
                        out_txd <= src_txd;
                        out_en  <= 1'b1;
                        out_er  <= src_er;
                    end
                end
                S_FRAME: begin
                    if (src_en) begin
                        out_txd <= src_txd;
                        out_en  <= 1'b1;
                        out_er  <= src_er;
                    end else begin
                        state     <= S_IDLE;
                        frame_cnt <= frame_cnt + 32'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 8'h00) begin
                        if (src_en) begin
                            if (drop_cnt != 16'hFFFF)
                                drop_cnt <= drop_cnt + 16'd1;
                            state <= S_DISC;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                S_DISC: begin
                    // Stage 1 holds reset values on the first cycle after
                    // release, so wait one cycle before trusting src_en.
                    if (warm && !src_en)
                        state <= S_IDLE;
                end
                default: state <= S_DISC;
            endcase
        end
    end

    assign bus.gmii_out_txd   = out_txd;
    assign bus.gmii_out_tx_en = out_en;
    assign bus.gmii_out_tx_er = out_er;
    assign bus.active_sel     = active_sel;
    assign bus.switch_pending = pending;
    assign bus.frame_count    = frame_cnt;
    assign bus.drop_count     = drop_cnt;
endmodule

// File: doc/gmii_frame_mux.md
Name: gmii_frame_mux

Overview:
- Parametrised N-input GMII transmit multiplexer: selects one of C_NUM_INPUTS GMII sources onto a single GMII output in the gtx_clk domain.
- Unlike a plain registered mux, the source switch is frame-safe: it is applied only between frames, followed by an enforced inter-frame gap.
- A frame already in progress on the new source is discarded rather than emitted truncated.
- Sits between the traffic generators/loopback paths and the MAC/PHY GMII port; select is driven by the cpu register block.

Parameters:
C_NUM_INPUTS, 8, number of GMII sources (2..16)
C_SEL_WIDTH, 8, width of select input
C_MIN_IFG, 12, idle cycles forced on output after every source switch (1..255)

Ports:
gtx_clk  in  1  125 MHz GMII clock; all logic on rising edge
gtx_resetn  in  1  asynchronous active-low reset
gmii_in_txd  in  8*C_NUM_INPUTS  source i data at bits [8i+7:8i]
gmii_in_tx_en  in  C_NUM_INPUTS  source i tx_en at bit i
gmii_in_tx_er  in  C_NUM_INPUTS  source i tx_er at bit i
select  in  C_SEL_WIDTH  requested source index (quasi-static, from register block)
gmii_out_txd  out  8  muxed data
gmii_out_tx_en  out  1  muxed tx_en
gmii_out_tx_er  out  1  muxed tx_er
active_sel  out  C_SEL_WIDTH  source index currently connected
switch_pending  out  1  1 while registered select differs from active_sel
frame_count  out  32  frames passed to output, wraps 0xFFFFFFFF->0
drop_count  out  16  frames discarded due to switch, saturates at 0xFFFF

Behaviour:
- Reset (async assert, sync release): all outputs 0; active_sel=0; state=DISCARD with no drop credit.
- Stage 1: all gmii_in_* and select registered every cycle (sel1, en1/er1/txd1 of every source).
- Stage 2: output registers. Data latency input->output = 2 cycles.
- src_en/src_er/src_txd = stage-1 values of source active_sel. If active_sel >= C_NUM_INPUTS, the source is disabled and src_en=0 permanently.
- switch_pending = (sel1 != active_sel), registered.
- State machine, evaluated each cycle on stage-1 values:
  - IDLE: output idle (txd=0, en=0, er=0).
    - If sel1 != active_sel: active_sel<=sel1, gap_cnt<=C_MIN_IFG-1, ->GAP. Switch has priority over a src_en rising in the same cycle; that frame on the old source is not emitted and not counted.
    - Else if src_en=1: ->FRAME and the output carries src data this same cycle.
  - FRAME: output = src_txd/src_en/src_er.
    - When src_en=0: output idle, ->IDLE, frame_count+1.
    - Select changes during FRAME are ignored until IDLE; the latest sel1 at the IDLE instant wins. Select returning to active_sel clears pending, so no switch occurs.
  - GAP: output idle; gap_cnt decrements each cycle.
    - At gap_cnt=0: if src_en=1 (new source mid-frame), drop_count+1 (saturating) and ->DISCARD; else ->IDLE.
    - A select change during GAP is deferred to the next IDLE.
  - DISCARD: output idle until src_en=0, then ->IDLE. After reset, DISCARD does not increment drop_count.
- tx_er without tx_en in IDLE/GAP/DISCARD is suppressed (output er=0). Carrier extension is not supported.
- Frame length is unlimited; there is no timeout.
- Reset mid-frame: output drops to idle immediately (async). After release, any frame in progress is discarded.

Test Plan:
- Reset release with source 0 mid-frame (tx_en=1 for 20 more cycles) -> output idle until that frame ends; next 64-byte frame on src 0 appears 2 cycles after input, frame_count=1, drop_count=0.
- select 0->3 while src 0 is 5 bytes into a 64-byte frame -> full 64 bytes of src 0 output, then ≥12 idle cycles, active_sel=3, switch_pending high until the switch, frame_count=1.
- Switch to src 2 while src 2 is mid-frame for 30 more cycles -> that frame fully suppressed, drop_count=1; src 2's next frame output intact.
- select=9 with C_NUM_INPUTS=8 -> after gap, output permanently idle, active_sel=9, frame_count frozen; select=1 -> src 1 frames resume after 12-cycle gap.
- select toggles 0->4->0 within one frame on src 0 -> no switch, no gap, back-to-back frames unaffected, switch_pending returns 0.
- Preload frame_count=0xFFFFFFFF (forced) and pass one frame -> wraps to 0; force drop_count=0xFFFF plus one drop -> stays 0xFFFF.
